// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro: UART_TX_PARITY_EN adds the ST_PARITY state.
package uart_pkg;

   localparam int   UART_DATA_BITS = 8;
   localparam logic UART_IDLE_LVL  = 1'b1;   // line level between frames and in reset

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read and push-while-full-with-pop.
// Latency: a pushed word is visible at rd_dat_o / !empty_o one clock after the push edge.
// Backpressure: push is refused (wr_ack_o=0) only when full and no pop happens in the same cycle.
// Ports: wr_en_i/wr_dat_i push side, rd_en_i pop side, rd_dat_o head word,
//        wr_ack_o push accepted, empty_o/full_o/count_o occupancy.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_dat_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_dat_o,
   output logic             wr_ack_o,
   output logic             empty_o,
   output logic             full_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             rd_ok;

   assign empty_o  = (count_q == '0);
   assign full_o   = (count_q == CW'(DEPTH));
   assign count_o  = count_q;
   assign rd_dat_o = mem_q[rd_ptr_q];

   // A pop frees the slot in the same cycle, so a full FIFO can still accept.
   assign rd_ok    = rd_en_i & ~empty_o;
   assign wr_ack_o = wr_en_i & (~full_o | rd_ok);

   always_comb begin
      count_d = count_q;
      case ({wr_ack_o, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (wr_ack_o) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_ok)    rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ack_o) mem_q[wr_ptr_q] <= wr_dat_i;
   end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO-fed 8N1 serializer, LSB first, registered tx.
// Latency: write into empty FIFO at edge k -> pop and start bit after edge k+1.
// Backpressure: none to the writer; a write to a full FIFO without a same-cycle pop is dropped and sets sticky ovf.
// Ports: clk, rst (async, active high), din/tx_en write side, tx serial line,
//        busy frame in progress, full FIFO full, ovf sticky overflow.
// Macro UART_TX_PARITY_EN: inserts an even-parity bit between data and stop.
module uart_tx_buf
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 5208,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       tx_en,
   output logic       tx,
   output logic       busy,
   output logic       full,
   output logic       ovf
);

   localparam int             BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

   uart_tx_state_t state_q, state_d;
   logic [BW-1:0]  baud_q, baud_d;
   logic [2:0]     bit_q, bit_d;
   logic [7:0]     shift_q, shift_d;
   logic           tx_q, tx_d;
   logic           ovf_q, ovf_d;
   logic           baud_end;
   logic           pop;
   logic           fifo_empty, fifo_full, wr_ack;
   logic [7:0]     fifo_dat;
   logic [CW-1:0]  fifo_count_unused;
`ifdef UART_TX_PARITY_EN
   logic           par_q, par_d;
`endif

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (tx_en),
      .wr_dat_i (din),
      .rd_en_i  (pop),
      .rd_dat_o (fifo_dat),
      .wr_ack_o (wr_ack),
      .empty_o  (fifo_empty),
      .full_o   (fifo_full),
      .count_o  (fifo_count_unused)
   );

   assign baud_end = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      // Baud counter parks at 0 in IDLE so every bit starts from a fresh count.
      baud_d  = (state_q == ST_IDLE || baud_end) ? '0 : baud_q + BW'(1);
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) pop = 1'b1;
         end
         ST_START: begin
            if (baud_end) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (baud_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (baud_end) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (baud_end) begin
               // Chain straight into the next frame when data is waiting.
               if (!fifo_empty) pop = 1'b1;
               else             state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pop) begin
         state_d = ST_START;
         shift_d = fifo_dat;
         bit_d   = '0;
`ifdef UART_TX_PARITY_EN
         par_d   = ^fifo_dat;
`endif
      end

      // Line level is decoded from next state so tx comes straight from a flop.
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = par_d;
`endif
         default:   tx_d = UART_IDLE_LVL;
      endcase

      ovf_d = ovf_q | (tx_en & ~wr_ack);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= UART_IDLE_LVL;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) par_q <= 1'b0;
      else     par_q <= par_d;
   end
`endif

   assign tx   = tx_q;
   assign busy = (state_q != ST_IDLE);
   assign full = fifo_full;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf with CLK_DIV=4, FIFO_DEPTH=4.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
// Also covers the parity build when UART_TX_PARITY_EN is defined.
module tb_uart_tx_buf;

   localparam int CLK_DIV = 4;
   localparam int DEPTH   = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME_CLKS = NB * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       tx_en;
   logic       tx, busy, full, ovf;

   int checks = 0;
   int passes = 0;

   logic       sch_en  [512];
   logic [7:0] sch_dat [512];
   logic       s_tx    [512];
   logic       s_busy  [512];
   logic       s_full  [512];
   logic       s_ovf   [512];
   logic [7:0] eb      [8];

   uart_tx_buf #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .din   (din),
      .tx_en (tx_en),
      .tx    (tx),
      .busy  (busy),
      .full  (full),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic clear_sched();
      for (int i = 0; i < 512; i++) begin
         sch_en[i]  = 1'b0;
         sch_dat[i] = 8'h00;
      end
   endtask

   // Starts just after a falling edge; sample c is taken after rising edge c.
   task automatic run(input int len);
      for (int c = 0; c < len; c++) begin
         tx_en = sch_en[c];
         din   = sch_dat[c];
         @(posedge clk);
         @(negedge clk);
         tx_en     = 1'b0;
         s_tx[c]   = tx;
         s_busy[c] = busy;
         s_full[c] = full;
         s_ovf[c]  = ovf;
      end
   endtask

   // Expected line when the first write lands at sample 0 with the FSM idle.
   function automatic logic exp_line(input int c, input int nfr);
      int p, f, j;
      if (c < 1) return 1'b1;
      p = c - 1;
      f = p / FRAME_CLKS;
      if (f >= nfr) return 1'b1;
      j = (p % FRAME_CLKS) / CLK_DIV;
      if (j == 0) return 1'b0;
      if (j <= 8) return eb[f][j-1];
`ifdef UART_TX_PARITY_EN
      if (j == 9) return ^eb[f];
`endif
      return 1'b1;
   endfunction

   task automatic test_reset();
      rst = 1'b1; tx_en = 1'b0; din = 8'h00;
      repeat (2) @(negedge clk);
      checks++; if (tx !== 1'b1)   $display("FAIL reset_tx got=%b exp=1", tx);   else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
      checks++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else passes++;
      checks++; if (ovf !== 1'b0)  $display("FAIL reset_ovf got=%b exp=0", ovf);  else passes++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic tbl [NB];
      int   nbusy;
`ifdef UART_TX_PARITY_EN
      tbl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`else
      tbl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
      clear_sched();
      sch_en[0] = 1'b1; sch_dat[0] = 8'h75;
      run(1 + FRAME_CLKS + 4);
      nbusy = 0;
      for (int c = 0; c < 1 + FRAME_CLKS + 4; c++) begin
         logic et, eb_;
         et  = (c >= 1 && c <= FRAME_CLKS) ? tbl[(c-1)/CLK_DIV] : 1'b1;
         eb_ = (c >= 1 && c <= FRAME_CLKS);
         if (s_busy[c] === 1'b1) nbusy++;
         checks++; if (s_tx[c] !== et)    $display("FAIL single_tx c=%0d got=%b exp=%b", c, s_tx[c], et);    else passes++;
         checks++; if (s_busy[c] !== eb_) $display("FAIL single_busy c=%0d got=%b exp=%b", c, s_busy[c], eb_); else passes++;
      end
`ifdef UART_TX_PARITY_EN
      checks++; if (nbusy != 44) $display("FAIL single_busy_len got=%0d exp=44", nbusy); else passes++;
`else
      checks++; if (nbusy != 40) $display("FAIL single_busy_len got=%0d exp=40", nbusy); else passes++;
`endif
   endtask

   task automatic test_burst();
      int len;
      eb[0] = 8'h75; eb[1] = 8'h0A; eb[2] = 8'h0B; eb[3] = 8'h0C; eb[4] = 8'h0D;
      clear_sched();
      for (int i = 0; i < 5; i++) begin sch_en[i] = 1'b1; sch_dat[i] = eb[i]; end
      len = 1 + 5 * FRAME_CLKS + 4;
      run(len);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (s_full[c] !== (c == 4)) $display("FAIL burst_full c=%0d got=%b exp=%b", c, s_full[c], (c == 4));
         else passes++;
      end
      for (int c = 0; c < len; c++) begin
         logic et, ebz;
         et  = exp_line(c, 5);
         ebz = (c >= 1 && c <= 5 * FRAME_CLKS);
         checks++; if (s_tx[c] !== et)    $display("FAIL burst_tx c=%0d got=%b exp=%b", c, s_tx[c], et);    else passes++;
         checks++; if (s_busy[c] !== ebz) $display("FAIL burst_busy c=%0d got=%b exp=%b", c, s_busy[c], ebz); else passes++;
      end
      checks++; if (s_ovf[len-1] !== 1'b0) $display("FAIL burst_ovf got=%b exp=0", s_ovf[len-1]); else passes++;
   endtask

   task automatic test_overflow();
      int len;
      for (int i = 0; i < 5; i++) eb[i] = 8'(i + 1);
      clear_sched();
      for (int i = 0; i < 6; i++) begin sch_en[i] = 1'b1; sch_dat[i] = 8'(i + 1); end
      len = 1 + 6 * FRAME_CLKS + 4;
      run(len);
      checks++; if (s_ovf[4] !== 1'b0) $display("FAIL ovf_before6 got=%b exp=0", s_ovf[4]); else passes++;
      checks++; if (s_ovf[5] !== 1'b1) $display("FAIL ovf_after6 got=%b exp=1", s_ovf[5]);  else passes++;
      checks++; if (s_ovf[len-1] !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", s_ovf[len-1]); else passes++;
      for (int c = 0; c < len; c++) begin
         logic et;
         et = exp_line(c, 5);
         checks++; if (s_tx[c] !== et) $display("FAIL ovf_tx c=%0d got=%b exp=%b", c, s_tx[c], et); else passes++;
      end
      checks++; if (s_busy[len-1] !== 1'b0) $display("FAIL ovf_idle_busy got=%b exp=0", s_busy[len-1]); else passes++;
   endtask

   task automatic test_reset_mid();
      checks++; if (ovf !== 1'b1) $display("FAIL midrst_pre_ovf got=%b exp=1", ovf); else passes++;
      clear_sched();
      for (int i = 0; i < 3; i++) begin sch_en[i] = 1'b1; sch_dat[i] = 8'h00; end
      run(12);
      checks++; if (s_tx[11] !== 1'b0)   $display("FAIL midrst_pre_tx got=%b exp=0", s_tx[11]);   else passes++;
      checks++; if (s_busy[11] !== 1'b1) $display("FAIL midrst_pre_busy got=%b exp=1", s_busy[11]); else passes++;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++; if (tx !== 1'b1)   $display("FAIL midrst_tx got=%b exp=1", tx);     else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passes++;
      checks++; if (full !== 1'b0) $display("FAIL midrst_full got=%b exp=0", full); else passes++;
      checks++; if (ovf !== 1'b0)  $display("FAIL midrst_ovf got=%b exp=0", ovf);   else passes++;
      @(negedge clk);
      rst = 1'b0;
      clear_sched();
      run(20);
      for (int c = 0; c < 20; c++) begin
         checks++; if (s_tx[c] !== 1'b1)   $display("FAIL midrst_flush_tx c=%0d got=%b exp=1", c, s_tx[c]);     else passes++;
         checks++; if (s_busy[c] !== 1'b0) $display("FAIL midrst_flush_busy c=%0d got=%b exp=0", c, s_busy[c]); else passes++;
      end
   endtask

   task automatic test_write_at_pop();
      int len;
      for (int i = 0; i < 6; i++) eb[i] = 8'h11 + 8'(i);
      clear_sched();
      for (int i = 0; i < 5; i++) begin sch_en[i] = 1'b1; sch_dat[i] = eb[i]; end
      sch_en[FRAME_CLKS+1]  = 1'b1;
      sch_dat[FRAME_CLKS+1] = eb[5];
      len = 1 + 6 * FRAME_CLKS + 4;
      run(len);
      checks++; if (s_full[FRAME_CLKS] !== 1'b1)   $display("FAIL pop_pre_full got=%b exp=1", s_full[FRAME_CLKS]);    else passes++;
      checks++; if (s_full[FRAME_CLKS+1] !== 1'b1) $display("FAIL pop_post_full got=%b exp=1", s_full[FRAME_CLKS+1]); else passes++;
      checks++; if (s_ovf[len-1] !== 1'b0)         $display("FAIL pop_ovf got=%b exp=0", s_ovf[len-1]);               else passes++;
      for (int c = 0; c < len; c++) begin
         logic et;
         et = exp_line(c, 6);
         checks++; if (s_tx[c] !== et) $display("FAIL pop_tx c=%0d got=%b exp=%b", c, s_tx[c], et); else passes++;
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic tbl [11];
      int   nbusy;
      tbl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      clear_sched();
      sch_en[0] = 1'b1; sch_dat[0] = 8'h03;
      run(1 + 44 + 4);
      nbusy = 0;
      for (int c = 0; c < 49; c++) begin
         logic et;
         et = (c >= 1 && c <= 44) ? tbl[(c-1)/CLK_DIV] : 1'b1;
         if (s_busy[c] === 1'b1) nbusy++;
         checks++; if (s_tx[c] !== et) $display("FAIL par03_tx c=%0d got=%b exp=%b", c, s_tx[c], et); else passes++;
      end
      checks++; if (nbusy != 44) $display("FAIL par03_len got=%0d exp=44", nbusy); else passes++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_reset_mid();
      test_write_at_pop();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_buf.md
# uart_tx_buf

Buffered 8N1 UART transmitter: accepts one byte per clock on a write strobe into an internal FIFO and serializes bytes LSB-first on `tx` at a fixed baud rate derived from the system clock. It sits between the user logic that produces bytes and the serial line, and bursts of back-to-back writes are absorbed without stalling the writer. Frames are emitted back-to-back with no idle gap while the FIFO is non-empty.

## Interface
- `CLK_DIV`, 5208: clocks per bit, e.g. 50 MHz / 9600; legal range ≥ 2.
- `FIFO_DEPTH`, 8: FIFO entries; must be a power of two ≥ 2.
- `clk` in 1: system clock; all logic on posedge.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `din` in 8: byte to send; sampled when `tx_en`=1.
- `tx_en` in 1: write strobe; one byte per asserted clock.
- `tx` out 1: serial line, idle high; reset value 1.
- `busy` out 1: 1 while a frame is on the line (any state except IDLE); reset 0.
- `full` out 1: FIFO holds `FIFO_DEPTH` entries; reset 0.
- `ovf` out 1: sticky overflow flag, cleared only by reset; reset 0.

## Operation
- Write: at posedge with `tx_en`=1, `din` is pushed if not full, or if full and a pop occurs in the same cycle. Otherwise the byte is dropped and `ovf` is set.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: `tx`=1. If FIFO is non-empty at a posedge: pop the head into the shift register, enter START, clear the bit counter.
- Each of START, DATA bits, PARITY and STOP lasts exactly `CLK_DIV` clocks. The baud counter runs 0..`CLK_DIV`-1 and wraps.
- START: `tx`=0.
- DATA: `tx` = shift[0], eight bits, LSB first; bit index 0..7.
- STOP: `tx`=1. At the end of STOP, if the FIFO is non-empty, pop and go directly to START with no idle cycle; else go to IDLE.
- `tx` is registered, so it never glitches.
- Reset mid-frame: `tx` returns to 1 immediately, the FIFO is flushed, the FSM goes to IDLE, and `ovf` clears.

## Timing
- Write at edge k into an empty FIFO with the FSM in IDLE: pop at edge k+1, and `tx` falls after edge k+1.
- Frame length: 10×`CLK_DIV` clocks, or 11×`CLK_DIV` with parity.
- `full` and `ovf` update at the same edge as the write that causes them.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- When defined: a PARITY state is inserted between DATA and STOP, and `tx` carries the XOR of the 8 data bits (even parity).
- When not defined: pure 8N1, with no PARITY state or logic.

## Structure
- Package `uart_pkg` holds:
  - `UART_DATA_BITS`=8
  - FSM state enum `uart_tx_state_t`
  - idle line level constant
- Sub-module `sync_fifo`:
  - parameterized width and depth
  - outputs empty/full/count
  - implements the simultaneous push/pop-when-full rule
- The FSM, baud counter and shift register live in `uart_tx_buf`.

## Test plan
All scenarios use the bench with `CLK_DIV`=4 and `FIFO_DEPTH`=4.
- Reset: `rst`=1 mid-frame → `tx`=1 asynchronously, and `busy`/`full`/`ovf`=0.
- Single byte 0x75 → `tx` = 0 (start), 1,0,1,0,1,1,1,0, then 1 (stop), each level held 4 clocks. `busy` is high for 40 clocks, then drops.
- Burst of 0x75, 0x0A, 0x0B, 0x0C, 0x0D on 5 consecutive clocks:
  - all five are accepted and `ovf` stays 0
  - `full` rises on the 5th write
  - five frames go out contiguously, 200 clocks with no idle bit
- Six consecutive writes 0x01..0x06 → `ovf`=1 after the 6th, and only 0x01..0x05 appear on `tx`.
- Write while full at the STOP→START pop edge → byte accepted, `ovf` stays 0.
- With `UART_TX_PARITY_EN`: 0x75 → parity bit 1 before stop, frame 44 clocks; 0x03 → parity bit 0.
